// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory request feeding a 2-entry
// {pc, inst} buffer, with redirect flushing and discard of in-flight responses.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign
);

   typedef enum logic [1:0] {
      FETCH,
      STALL,
      DISCARD
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_e      state_q;
   logic        req_q;
   logic [31:0] addr_q;
   logic [31:0] target_q;
   entry_t      buf_q [2];
   logic        rd_ptr_q;
   logic        wr_ptr_q;
   logic [1:0]  count_q;
   logic        misalign_q;

   logic        acked;
   logic        push;
   logic        pop;
   logic [1:0]  count_d;
   logic [31:0] redirect_tgt;

   assign acked        = req_q & imem_ack;
   assign push         = (state_q == FETCH) & acked & ~redirect;
   assign pop          = (count_q != 2'd0) & inst_ready & ~redirect;
   assign count_d      = count_q + {1'b0, push} - {1'b0, pop};
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         target_q   <= RESET_PC;
         // NOTE: the two buffer slots are reset because inst/inst_pc are
         // visible outputs that must read zero while in reset.
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         misalign_q <= 1'b0;
      end else begin
         if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
         end

         if (redirect) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            // An unacked request must keep its address stable, so park the target.
            if (req_q && !imem_ack) begin
               state_q  <= DISCARD;
               target_q <= redirect_tgt;
            end else begin
               state_q <= FETCH;
               req_q   <= 1'b1;
               addr_q  <= redirect_tgt;
            end
         end else begin
            if (push) begin
               buf_q[wr_ptr_q] <= entry_t'{pc: addr_q, inst: imem_rdata};
               wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;

            case (state_q)
               FETCH: begin
                  if (acked) begin
                     addr_q <= addr_q + 32'd4;
                     if (count_d == 2'd2) begin
                        req_q   <= 1'b0;
                        state_q <= STALL;
                     end
                  end else if (!req_q) begin
                     req_q <= 1'b1;
                  end
               end
               STALL: begin
                  if (pop) begin
                     req_q   <= 1'b1;
                     state_q <= FETCH;
                  end
               end
               DISCARD: begin
                  if (acked) begin
                     addr_q  <= target_q;
                     state_q <= FETCH;
                  end
               end
               default: state_q <= FETCH;
            endcase
         end
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst       = buf_q[rd_ptr_q].inst;
   assign inst_pc    = buf_q[rd_ptr_q].pc;
   assign misalign   = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed latency/stall/redirect/reset scenarios, then a
// randomized run scored against an expected-pc stream model.
module tb_inst_fetch;

   localparam logic [31:0] KEY     = 32'hA5A5_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        misalign;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_valid;
   logic        w_misalign;
   logic        w_ack = 1'b1;
   logic        w_ready = 1'b1;
   logic        w_redirect = 1'b0;
   logic [31:0] w_redirect_pc = '0;

   int checks = 0;
   int errors = 0;
   int mem_waits = 0;
   int wait_cnt = 0;

   assign imem_rdata = imem_addr ^ KEY;
   assign w_rdata    = w_addr ^ KEY;

   always #5 clk = ~clk;

   inst_fetch u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .misalign   (misalign)
   );

   inst_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (w_req),
      .imem_addr  (w_addr),
      .imem_ack   (w_ack),
      .imem_rdata (w_rdata),
      .inst       (w_inst),
      .inst_pc    (w_inst_pc),
      .inst_valid (w_valid),
      .inst_ready (w_ready),
      .redirect   (w_redirect),
      .redirect_pc(w_redirect_pc),
      .misalign   (w_misalign)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory with a fixed number of wait cycles before each ack.
   task automatic mem_step();
      if (imem_req && wait_cnt >= mem_waits) begin
         imem_ack = 1'b1;
         wait_cnt = 0;
      end else begin
         imem_ack = 1'b0;
         if (imem_req) wait_cnt++;
         else          wait_cnt = 0;
      end
   endtask

   task automatic cycle();
      mem_step();
      @(negedge clk);
   endtask

   // Returns at the negedge following the first rising edge after release.
   task automatic apply_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      redirect   = 1'b0;
      wait_cnt   = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [31:0] pc_e;
      logic [31:0] exp_pc;
      logic        exp_mis;
      logic        flushed;
      logic        prev_req;
      logic        prev_ack;
      logic [31:0] prev_addr;
      int          consumed;

      // Reset state, then zero-wait streaming (also the wrapping instance).
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_misalign", misalign, 1'b0);
      check("rst_wrap_addr", w_addr, WRAP_PC);
      imem_ack  = 1'b0;
      mem_waits = 0;
      wait_cnt  = 0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("first_req", imem_req, 1'b1);
      check("first_addr", imem_addr, 32'h0);
      check("first_valid", inst_valid, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cycle();
         pc_e = 32'(4 * k);
         check("stream_valid", inst_valid, 1'b1);
         check("stream_pc", inst_pc, pc_e);
         check("stream_inst", inst, pc_e ^ KEY);
         pc_e = WRAP_PC + 32'(4 * k);
         check("wrap_pc", w_inst_pc, pc_e);
         check("wrap_inst", w_inst, pc_e ^ KEY);
      end

      // Consumer stalled: buffer fills to two, request drops, one pop restarts at 8.
      apply_reset();
      mem_waits = 0;
      cycle();
      cycle();
      check("full_req", imem_req, 1'b0);
      check("full_addr", imem_addr, 32'h8);
      check("full_head", inst_pc, 32'h0);
      cycle();
      check("stall_req", imem_req, 1'b0);
      inst_ready = 1'b1;
      cycle();
      inst_ready = 1'b0;
      check("pop_req", imem_req, 1'b1);
      check("pop_addr", imem_addr, 32'h8);
      check("pop_head", inst_pc, 32'h4);
      check("pop_valid", inst_valid, 1'b1);

      // Reset dropped mid-cycle with a request pending; acks during reset ignored.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", inst_valid, 1'b0);
      check("midrst_req", imem_req, 1'b0);
      check("midrst_addr", imem_addr, 32'h0);
      imem_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("inrst_req", imem_req, 1'b0);
      check("inrst_valid", inst_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_req", imem_req, 1'b1);
      check("rel_addr", imem_addr, 32'h0);
      check("rel_valid", inst_valid, 1'b0);
      @(negedge clk);
      check("rel_push_pc", inst_pc, 32'h0);
      imem_ack = 1'b0;

      // Three-wait memory; redirect while the fetch of address 8 is in flight.
      apply_reset();
      inst_ready = 1'b1;
      mem_waits  = 3;
      n = 0;
      while (imem_addr != 32'h8 && n < 40) begin
         cycle();
         n++;
      end
      check("reach_addr8", imem_addr, 32'h8);
      cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      cycle();
      redirect = 1'b0;
      check("disc_req", imem_req, 1'b1);
      check("disc_addr", imem_addr, 32'h8);
      n = 0;
      while (imem_addr == 32'h8 && n < 10) begin
         check("disc_valid", inst_valid, 1'b0);
         check("disc_req_held", imem_req, 1'b1);
         cycle();
         n++;
      end
      check("disc_new_addr", imem_addr, 32'h100);
      check("disc_new_req", imem_req, 1'b1);
      check("disc_dropped", inst_valid, 1'b0);
      n = 0;
      while (!inst_valid && n < 20) begin
         cycle();
         n++;
      end
      check("disc_first_valid", inst_valid, 1'b1);
      check("disc_first_pc", inst_pc, 32'h100);
      check("disc_first_inst", inst, 32'h100 ^ KEY);

      // Redirect, ack and pop together with a full buffer.
      apply_reset();
      mem_waits = 0;
      cycle();
      cycle();
      check("rd3_full_valid", inst_valid, 1'b1);
      check("rd3_full_req", imem_req, 1'b0);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      inst_ready  = 1'b1;
      imem_ack    = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      check("rd3_valid", inst_valid, 1'b0);
      check("rd3_req", imem_req, 1'b1);
      check("rd3_addr", imem_addr, 32'h200);
      check("rd3_misalign", misalign, 1'b0);
      cycle();
      check("rd3_first_pc", inst_pc, 32'h200);

      // Misaligned redirect target is truncated and the flag sticks.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      cycle();
      redirect = 1'b0;
      check("mis_addr", imem_addr, 32'h100);
      check("mis_req", imem_req, 1'b1);
      check("mis_flag", misalign, 1'b1);
      check("mis_valid", inst_valid, 1'b0);
      cycle();
      check("mis_first_pc", inst_pc, 32'h100);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("mis_sticky", misalign, 1'b1);
      end

      // Randomized run against the expected fetch-stream model.
      apply_reset();
      exp_pc    = 32'h0;
      exp_mis   = 1'b0;
      flushed   = 1'b0;
      prev_req  = imem_req;
      prev_ack  = 1'b0;
      prev_addr = imem_addr;
      consumed  = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_req && !prev_ack) begin
            check("rand_req_hold", imem_req, 1'b1);
            check("rand_addr_hold", imem_addr, prev_addr);
         end
         if (flushed) check("rand_flush", inst_valid, 1'b0);
         if (inst_valid) check("rand_inst_word", inst, inst_pc ^ KEY);
         check("rand_misalign", misalign, exp_mis);

         imem_ack    = ($urandom_range(0, 3) != 0);
         inst_ready  = ($urandom_range(0, 2) != 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;

         if (inst_valid && inst_ready && !redirect) begin
            check("rand_inst_pc", inst_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (redirect) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
         end
         flushed   = redirect;
         prev_req  = imem_req;
         prev_ack  = imem_ack;
         prev_addr = imem_addr;
         @(negedge clk);
      end
      redirect = 1'b0;
      check("rand_liveness", 32'(consumed > 300), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
